// File: rtl/divider_pkg.sv
// Shared width constant and FSM state encoding for the 8-bit restoring divider.
package divider_pkg;

    localparam int DIV_W = 8;

    // SHIFTk/TRIALk alternate so each step's successor is simply the next code;
    // TRIAL7 + 1 lands on HOLD.
    typedef enum logic [4:0] {
        IDLE   = 5'd0,
        SHIFT0 = 5'd1,  TRIAL0 = 5'd2,
        SHIFT1 = 5'd3,  TRIAL1 = 5'd4,
        SHIFT2 = 5'd5,  TRIAL2 = 5'd6,
        SHIFT3 = 5'd7,  TRIAL3 = 5'd8,
        SHIFT4 = 5'd9,  TRIAL4 = 5'd10,
        SHIFT5 = 5'd11, TRIAL5 = 5'd12,
        SHIFT6 = 5'd13, TRIAL6 = 5'd14,
        SHIFT7 = 5'd15, TRIAL7 = 5'd16,
        HOLD   = 5'd17
    } div_state_t;

endpackage

// File: rtl/divider_8bit_if.sv
// Switch/button side of the divider: RUN/LOADD/S in, result and status out.
interface divider_8bit_if import divider_pkg::*; ();

    logic             RUN;
    logic             LOADD;
    logic [DIV_W-1:0] S;
    logic [DIV_W-1:0] Q;
    logic [DIV_W-1:0] R;
    logic [DIV_W-1:0] DVSR;
    logic             DIVZERO;
    logic             DONE;

    modport master (output RUN, LOADD, S, input Q, R, DVSR, DIVZERO, DONE);
    modport slave  (input RUN, LOADD, S, output Q, R, DVSR, DIVZERO, DONE);

endinterface

// File: rtl/div_control.sv
// One-state-per-step control FSM: IDLE, eight SHIFT/TRIAL pairs, then HOLD until RUN drops.
module div_control import divider_pkg::*; (
    input  logic CLK,
    input  logic RESET,
    input  logic RUN,
    input  logic LOADD,
    input  logic DZ,
    input  logic NEG,
    output logic LD_D,
    output logic START,
    output logic START_DZ,
    output logic SHIFT_EN,
    output logic TRIAL_EN,
    output logic DONE
);

    div_state_t state_q, state_d;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d  = state_q;
        LD_D     = 1'b0;
        START    = 1'b0;
        START_DZ = 1'b0;
        SHIFT_EN = 1'b0;
        TRIAL_EN = 1'b0;
        DONE     = 1'b0;
        case (state_q)
            IDLE: begin
                if (LOADD) begin
                    LD_D = 1'b1;
                end else if (RUN) begin
                    if (DZ) begin
                        START_DZ = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        START   = 1'b1;
                        state_d = SHIFT0;
                    end
                end
            end
            SHIFT0, SHIFT1, SHIFT2, SHIFT3, SHIFT4, SHIFT5, SHIFT6, SHIFT7: begin
                SHIFT_EN = 1'b1;
                state_d  = div_state_t'(state_q + 5'd1);
            end
            TRIAL0, TRIAL1, TRIAL2, TRIAL3, TRIAL4, TRIAL5, TRIAL6, TRIAL7: begin
                // Commit the subtraction only when it did not go negative.
                TRIAL_EN = ~NEG;
                state_d  = div_state_t'(state_q + 5'd1);
            end
            HOLD: begin
                DONE = 1'b1;
                if (!RUN) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/divider_8bit.sv
// Restoring divider datapath: divisor D, quotient/dividend Q, 9-bit partial remainder P.
module divider_8bit import divider_pkg::*; (
    input  logic           CLK,
    input  logic           RESET,
    divider_8bit_if.slave  bus
);

    logic [DIV_W-1:0] d_q, d_d;
    logic [DIV_W-1:0] q_q, q_d;
    logic [DIV_W:0]   p_q, p_d;
    logic             divzero_q, divzero_d;
    logic [DIV_W+1:0] diff;

    logic ld_d, start, start_dz, shift_en, trial_en;

    // Extra top bit of the 10-bit difference is the borrow that rejects a trial.
    assign diff = {1'b0, p_q} - {2'b0, d_q};

    div_control u_ctrl (
        .CLK      (CLK),
        .RESET    (RESET),
        .RUN      (bus.RUN),
        .LOADD    (bus.LOADD),
        .DZ       (d_q == '0),
        .NEG      (diff[DIV_W+1]),
        .LD_D     (ld_d),
        .START    (start),
        .START_DZ (start_dz),
        .SHIFT_EN (shift_en),
        .TRIAL_EN (trial_en),
        .DONE     (bus.DONE)
    );

    always_comb begin
        d_d       = d_q;
        q_d       = q_q;
        p_d       = p_q;
        divzero_d = divzero_q;
        if (ld_d) d_d = bus.S;
        if (start) begin
            q_d       = bus.S;
            p_d       = '0;
            divzero_d = 1'b0;
        end
        if (start_dz) begin
            q_d       = '1;
            p_d       = {1'b0, bus.S};
            divzero_d = 1'b1;
        end
        if (shift_en) {p_d, q_d} = {p_q[DIV_W-1:0], q_q, 1'b0};
        if (trial_en) begin
            p_d    = diff[DIV_W:0];
            q_d[0] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            d_q       <= '0;
            q_q       <= '0;
            p_q       <= '0;
            divzero_q <= 1'b0;
        end else begin
            d_q       <= d_d;
            q_q       <= q_d;
            p_q       <= p_d;
            divzero_q <= divzero_d;
        end
    end

    assign bus.Q       = q_q;
    assign bus.R       = p_q[DIV_W-1:0];
    assign bus.DVSR    = d_q;
    assign bus.DIVZERO = divzero_q;

endmodule

// File: tb/tb_divider_8bit.sv
// Directed bench for divider_8bit with an expected-result scoreboard queue.
module tb_divider_8bit;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;
    int   vectors = 0;
    int   miscompares = 0;
    int   edges = 0;
    logic [7:0] model_d = 8'd0;
    exp_t sb[$];

    divider_8bit_if bus ();

    divider_8bit dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
        edges++;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_d(input logic [7:0] v);
        bus.LOADD = 1'b1;
        bus.S     = v;
        tick();
        bus.LOADD = 1'b0;
        model_d   = v;
        check("dvsr_load", {8'd0, bus.DVSR}, {8'd0, v});
    endtask

    // Drive a start and push the bench-computed result; returns after edge E0.
    task automatic start_div(input logic [7:0] s);
        exp_t e;
        if (model_d == 8'd0) begin
            e.q = 8'hFF; e.r = s; e.dz = 1'b1; e.lat = 0;
        end else begin
            e.q = s / model_d; e.r = s % model_d; e.dz = 1'b0; e.lat = 16;
        end
        sb.push_back(e);
        bus.S   = s;
        bus.RUN = 1'b1;
        edges   = 0;
        tick();
    endtask

    // Wait (bounded) for DONE, then compare against the oldest expectation. RUN stays high.
    task automatic wait_result(input string tag);
        exp_t e;
        while (!bus.DONE && edges < 60) tick();
        check({tag, "_done"}, {15'd0, bus.DONE}, 16'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_lat"}, 16'(edges - 1), 16'(e.lat));
            check({tag, "_q"}, {8'd0, bus.Q}, {8'd0, e.q});
            check({tag, "_r"}, {8'd0, bus.R}, {8'd0, e.r});
            check({tag, "_dz"}, {15'd0, bus.DIVZERO}, {15'd0, e.dz});
        end
    endtask

    task automatic release_run(input string tag);
        bus.RUN = 1'b0;
        tick();
        check({tag, "_idle"}, {15'd0, bus.DONE}, 16'd0);
    endtask

    initial begin
        RESET     = 1'b1;
        bus.RUN   = 1'b0;
        bus.LOADD = 1'b0;
        bus.S     = 8'd0;
        tick();
        tick();
        RESET = 1'b0;
        check("rst_q", {8'd0, bus.Q}, 16'd0);
        check("rst_r", {8'd0, bus.R}, 16'd0);
        check("rst_dvsr", {8'd0, bus.DVSR}, 16'd0);
        check("rst_dz", {15'd0, bus.DIVZERO}, 16'd0);
        check("rst_done", {15'd0, bus.DONE}, 16'd0);

        // Divide by zero straight out of reset.
        start_div(8'd77);
        wait_result("dz77");
        release_run("dz77");

        // Normal divide 200/7, then hold RUN high for 10 cycles.
        load_d(8'd7);
        start_div(8'd200);
        wait_result("d200_7");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_done", {15'd0, bus.DONE}, 16'd1);
            check("hold_q", {8'd0, bus.Q}, 16'd28);
        end
        release_run("hold");

        // Retained divisor: 100/7.
        start_div(8'd100);
        wait_result("d100_7");
        release_run("d100_7");

        // LOADD during SHIFT2 must be ignored.
        start_div(8'd200);
        repeat (4) tick();
        bus.LOADD = 1'b1;
        bus.S     = 8'd3;
        tick();
        bus.LOADD = 1'b0;
        wait_result("busy_load");
        check("busy_dvsr", {8'd0, bus.DVSR}, 16'd7);
        release_run("busy_load");

        // LOADD has priority over RUN in IDLE.
        bus.RUN = 1'b1;
        load_d(8'd1);
        check("load_prio_done", {15'd0, bus.DONE}, 16'd0);
        bus.RUN = 1'b0;
        tick();

        // Extremes.
        start_div(8'd255);
        wait_result("d255_1");
        release_run("d255_1");
        load_d(8'd255);
        start_div(8'd255);
        wait_result("d255_255");
        release_run("d255_255");
        load_d(8'd9);
        start_div(8'd5);
        wait_result("d5_9");
        release_run("d5_9");

        // Reset during TRIAL4 (after E10) aborts with nothing retained.
        load_d(8'd7);
        start_div(8'd200);
        repeat (9) tick();
        RESET = 1'b1;
        tick();
        RESET   = 1'b0;
        bus.RUN = 1'b0;
        sb.delete();
        model_d = 8'd0;
        check("abort_q", {8'd0, bus.Q}, 16'd0);
        check("abort_r", {8'd0, bus.R}, 16'd0);
        check("abort_dvsr", {8'd0, bus.DVSR}, 16'd0);
        check("abort_done", {15'd0, bus.DONE}, 16'd0);
        tick();
        start_div(8'd77);
        wait_result("post_abort_dz");
        release_run("post_abort_dz");

        check("sb_drained", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
